tlc_supervisor: RTL and testbench

TLC_SUPERVISOR -- requirements
Module: tlc_supervisor

---
 rtl/tlc_supervisor.sv | 131 +++++++++++++
 tb/tb_tlc_supervisor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_supervisor.sv
// Traffic-light controller supervisor: button debounce, pedestrian request handshake,
// conflict/watchdog monitoring and controller reset sequencing. Watchdog built only with TLC_SUP_WATCHDOG_EN.
module tlc_supervisor #(
  parameter int unsigned DB_CYCLES  = 3,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned WD_LIMIT   = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic [2:0] L_A,
  input  logic [2:0] L_B,
  input  logic       RA,
  input  logic       RB,
  input  logic       clr_err,
  output logic       PA,
  output logic       PB,
  output logic       ERR,
  output logic       tlc_reset,
  output logic [1:0] fault_code
);

  localparam logic [2:0] GREEN = 3'b110;
  localparam logic [2:0] RED   = 3'b011;
  localparam int unsigned DBW  = $clog2(DB_CYCLES + 1);
  localparam int unsigned RCW  = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {INIT, RUN, FAULT, RECOVER} state_t;

  state_t         state;
  logic [RCW-1:0] rst_cnt;
  logic [DBW-1:0] db_a;
  logic [DBW-1:0] db_b;
  logic           conflict;
  logic           wd_hit;
  logic           acc_a;
  logic           acc_b;

  assign conflict = (L_A == GREEN && L_B != RED) || (L_B == GREEN && L_A != RED);

  // Acceptance is the cycle whose closing edge takes the counter to DB_CYCLES;
  // the counter then saturates so a held button is accepted only once.
  assign acc_a = btn_a && (db_a == DBW'(DB_CYCLES - 1));
  assign acc_b = btn_b && (db_b == DBW'(DB_CYCLES - 1));

`ifdef TLC_SUP_WATCHDOG_EN
  localparam int unsigned WDW = $clog2(WD_LIMIT + 1);

  logic [5:0]     prev_l;
  logic [WDW-1:0] wd_cnt;
  logic           lights_changed;

  assign lights_changed = ({L_A, L_B} != prev_l);
  assign wd_hit         = !lights_changed && (wd_cnt == WDW'(WD_LIMIT - 1));

  always_ff @(posedge CLK) begin
    prev_l <= {L_A, L_B};
    if (reset || state != RUN || lights_changed || wd_hit)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 1'b1;
  end
`else
  // Watchdog compiled out: WD_LIMIT has no effect in this build.
  assign wd_hit = 1'b0 && (WD_LIMIT != 0);
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= INIT;
      rst_cnt    <= '0;
      tlc_reset  <= 1'b1;
      ERR        <= 1'b0;
      fault_code <= '0;
      PA         <= 1'b0;
      PB         <= 1'b0;
      db_a       <= '0;
      db_b       <= '0;
    end else begin
      if (!btn_a)
        db_a <= '0;
      else if (db_a != DBW'(DB_CYCLES))
        db_a <= db_a + 1'b1;
      if (!btn_b)
        db_b <= '0;
      else if (db_b != DBW'(DB_CYCLES))
        db_b <= db_b + 1'b1;

      case (state)
        INIT, RECOVER: begin
          if (rst_cnt == RCW'(RST_CYCLES - 1)) begin
            state     <= RUN;
            tlc_reset <= 1'b0;
            rst_cnt   <= '0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        RUN: begin
          if (conflict || wd_hit) begin
            state      <= FAULT;
            ERR        <= 1'b1;
            fault_code <= fault_code | {wd_hit, conflict};
            PA         <= 1'b0;
            PB         <= 1'b0;
            db_a       <= '0;
            db_b       <= '0;
          end else begin
            // A fresh acceptance wins over a same-cycle acknowledgement.
            PA <= acc_a || (PA && !RA);
            PB <= acc_b || (PB && !RB);
          end
        end
        FAULT: begin
          if (clr_err) begin
            state      <= RECOVER;
            rst_cnt    <= '0;
            tlc_reset  <= 1'b1;
            ERR        <= 1'b0;
            fault_code <= '0;
            db_a       <= '0;
            db_b       <= '0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_tlc_supervisor.sv
// Directed bench for tlc_supervisor: reset sequencing, debounce/handshake, conflict and
// watchdog faults, clear/recover and reset priority. Observed vector is {tlc_reset,ERR,PA,PB,fault_code}.
module tb_tlc_supervisor;

  logic       CLK = 1'b0;
  logic       reset, btn_a, btn_b, RA, RB, clr_err;
  logic [2:0] L_A, L_B;
  logic       PA, PB, ERR, tlc_reset;
  logic [1:0] fault_code;
  logic       auto_lights;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  tlc_supervisor #(.DB_CYCLES(3), .RST_CYCLES(4), .WD_LIMIT(16)) dut (
    .CLK(CLK), .reset(reset), .btn_a(btn_a), .btn_b(btn_b),
    .L_A(L_A), .L_B(L_B), .RA(RA), .RB(RB), .clr_err(clr_err),
    .PA(PA), .PB(PB), .ERR(ERR), .tlc_reset(tlc_reset), .fault_code(fault_code)
  );

  always #5 CLK = ~CLK;

  // Safe lights alternate every cycle so the watchdog never trips outside its own test.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (auto_lights) L_A = (L_A == 3'b011) ? 3'b100 : 3'b011;
  endtask

  task automatic safe_lights();
    auto_lights = 1'b1;
    L_A = 3'b011;
    L_B = 3'b011;
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_a = 1'b0; btn_b = 1'b0; RA = 1'b0; RB = 1'b0; clr_err = 1'b0;
    safe_lights();
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({tlc_reset, ERR, PA, PB, fault_code} !== 6'b100000) begin
        n_fail++;
        $display("FAIL reset_state[%0d] got=%b exp=%b", i, {tlc_reset, ERR, PA, PB, fault_code}, 6'b100000);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({tlc_reset, ERR, PA, PB, fault_code} !== 6'b100000) begin
        n_fail++;
        $display("FAIL init_hold[%0d] got=%b exp=%b", i, {tlc_reset, ERR, PA, PB, fault_code}, 6'b100000);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({tlc_reset, ERR, PA, PB, fault_code} !== 6'b000000) begin
        n_fail++;
        $display("FAIL init_exit[%0d] got=%b exp=%b", i, {tlc_reset, ERR, PA, PB, fault_code}, 6'b000000);
      end
    end
  endtask

  task automatic test_debounce_a();
    logic [4:0] pat;
    pat = 5'b11101;
    for (int i = 0; i < 5; i++) begin
      btn_a = pat[i];
      tick();
      n_checks++;
      if ({PA, PB} !== {(i == 4), 1'b0}) begin
        n_fail++;
        $display("FAIL debounce_a[%0d] got=%b exp=%b", i, {PA, PB}, {(i == 4), 1'b0});
      end
    end
    RB = 1'b1;
    tick();
    RB = 1'b0;
    n_checks++;
    if ({PA, PB} !== 2'b10) begin
      n_fail++;
      $display("FAIL pa_hold_wrong_ack got=%b exp=%b", {PA, PB}, 2'b10);
    end
    RA = 1'b1;
    tick();
    RA = 1'b0;
    n_checks++;
    if ({PA, PB} !== 2'b00) begin
      n_fail++;
      $display("FAIL pa_ack_clear got=%b exp=%b", {PA, PB}, 2'b00);
    end
    tick();
    n_checks++;
    if ({PA, PB} !== 2'b00) begin
      n_fail++;
      $display("FAIL pa_once_per_press got=%b exp=%b", {PA, PB}, 2'b00);
    end
    btn_a = 1'b0;
    tick();
  endtask

  task automatic test_merge_b();
    for (int p = 0; p < 2; p++) begin
      btn_b = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        n_checks++;
        if ({PA, PB} !== {1'b0, (p == 1 || i == 2)}) begin
          n_fail++;
          $display("FAIL merge_b[%0d.%0d] got=%b exp=%b", p, i, {PA, PB}, {1'b0, (p == 1 || i == 2)});
        end
      end
      btn_b = 1'b0;
      if (p == 0) tick();
    end
    RB = 1'b1;
    tick();
    RB = 1'b0;
    n_checks++;
    if ({PA, PB} !== 2'b00) begin
      n_fail++;
      $display("FAIL pb_ack_clear got=%b exp=%b", {PA, PB}, 2'b00);
    end
    tick();
    n_checks++;
    if ({PA, PB} !== 2'b00) begin
      n_fail++;
      $display("FAIL pb_no_queue got=%b exp=%b", {PA, PB}, 2'b00);
    end
  endtask

  task automatic test_conflict();
    auto_lights = 1'b0;
    L_A = 3'b110; L_B = 3'b011;
    tick();
    n_checks++;
    if ({tlc_reset, ERR, PA, PB, fault_code} !== 6'b000000) begin
      n_fail++;
      $display("FAIL green_vs_red_ok got=%b exp=%b", {tlc_reset, ERR, PA, PB, fault_code}, 6'b000000);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_checks++;
    if ({tlc_reset, ERR, PA, PB, fault_code} !== 6'b000000) begin
      n_fail++;
      $display("FAIL clr_in_run got=%b exp=%b", {tlc_reset, ERR, PA, PB, fault_code}, 6'b000000);
    end
    safe_lights();
    btn_a = 1'b1;
    repeat (3) tick();
    btn_a = 1'b0;
    n_checks++;
    if ({tlc_reset, ERR, PA, PB, fault_code} !== 6'b001000) begin
      n_fail++;
      $display("FAIL pa_pending got=%b exp=%b", {tlc_reset, ERR, PA, PB, fault_code}, 6'b001000);
    end
    auto_lights = 1'b0;
    L_A = 3'b110; L_B = 3'b101;
    tick();
    n_checks++;
    if ({tlc_reset, ERR, PA, PB, fault_code} !== 6'b010001) begin
      n_fail++;
      $display("FAIL conflict_fault got=%b exp=%b", {tlc_reset, ERR, PA, PB, fault_code}, 6'b010001);
    end
    btn_b = 1'b1;
    repeat (3) tick();
    btn_b = 1'b0;
    n_checks++;
    if ({tlc_reset, ERR, PA, PB, fault_code} !== 6'b010001) begin
      n_fail++;
      $display("FAIL fault_hold got=%b exp=%b", {tlc_reset, ERR, PA, PB, fault_code}, 6'b010001);
    end
    clr_err = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      clr_err = 1'b0;
      n_checks++;
      if ({tlc_reset, ERR, PA, PB, fault_code} !== 6'b100000) begin
        n_fail++;
        $display("FAIL recover_hold[%0d] got=%b exp=%b", i, {tlc_reset, ERR, PA, PB, fault_code}, 6'b100000);
      end
      if (i == 0) clr_err = 1'b1;
      if (i == 2) safe_lights();
    end
    tick();
    n_checks++;
    if ({tlc_reset, ERR, PA, PB, fault_code} !== 6'b000000) begin
      n_fail++;
      $display("FAIL recover_exit got=%b exp=%b", {tlc_reset, ERR, PA, PB, fault_code}, 6'b000000);
    end
  endtask

  task automatic test_reset_priority();
    auto_lights = 1'b0;
    L_A = 3'b100; L_B = 3'b110;
    tick();
    n_checks++;
    if ({tlc_reset, ERR, PA, PB, fault_code} !== 6'b010001) begin
      n_fail++;
      $display("FAIL conflict_b got=%b exp=%b", {tlc_reset, ERR, PA, PB, fault_code}, 6'b010001);
    end
    for (int pass = 0; pass < 2; pass++) begin
      reset = 1'b1;
      clr_err = (pass == 0);
      if (pass == 1) begin
        auto_lights = 1'b0;
        L_A = 3'b110; L_B = 3'b101;
      end
      tick();
      reset = 1'b0;
      n_checks++;
      if ({tlc_reset, ERR, PA, PB, fault_code} !== 6'b100000) begin
        n_fail++;
        $display("FAIL reset_priority[%0d] got=%b exp=%b", pass, {tlc_reset, ERR, PA, PB, fault_code}, 6'b100000);
      end
      for (int i = 0; i < 3; i++) begin
        tick();
        clr_err = 1'b0;
        n_checks++;
        if ({tlc_reset, ERR, PA, PB, fault_code} !== 6'b100000) begin
          n_fail++;
          $display("FAIL reinit_hold[%0d.%0d] got=%b exp=%b", pass, i, {tlc_reset, ERR, PA, PB, fault_code}, 6'b100000);
        end
      end
      safe_lights();
      for (int i = 0; i < 2; i++) begin
        tick();
        n_checks++;
        if ({tlc_reset, ERR, PA, PB, fault_code} !== 6'b000000) begin
          n_fail++;
          $display("FAIL reinit_exit[%0d.%0d] got=%b exp=%b", pass, i, {tlc_reset, ERR, PA, PB, fault_code}, 6'b000000);
        end
      end
    end
  endtask

  task automatic test_watchdog();
    auto_lights = 1'b0;
    L_A = 3'b011; L_B = 3'b110;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_checks++;
      if ({tlc_reset, ERR, PA, PB, fault_code} !== 6'b000000) begin
        n_fail++;
        $display("FAIL wd_quiet[%0d] got=%b exp=%b", i, {tlc_reset, ERR, PA, PB, fault_code}, 6'b000000);
      end
    end
    tick();
`ifdef TLC_SUP_WATCHDOG_EN
    n_checks++;
    if ({tlc_reset, ERR, PA, PB, fault_code} !== 6'b010010) begin
      n_fail++;
      $display("FAIL wd_fault got=%b exp=%b", {tlc_reset, ERR, PA, PB, fault_code}, 6'b010010);
    end
`else
    repeat (4) tick();
    n_checks++;
    if ({tlc_reset, ERR, PA, PB, fault_code} !== 6'b000000) begin
      n_fail++;
      $display("FAIL wd_absent got=%b exp=%b", {tlc_reset, ERR, PA, PB, fault_code}, 6'b000000);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_debounce_a();
    test_merge_b();
    test_conflict();
    test_reset_priority();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
